sram_pipe_ctrl: RTL and testbench
=================================

SRAM_PIPE_CTRL -- requirements
Module: sram_pipe_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, word address width; depth is 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 8, word width; SHALL be a multiple of 8.
REQ-003 Parameter RD_LATENCY, default 1, read latency in cycles; legal range 1..4.
REQ-004 Parameter RSP_DEPTH, default 4, response buffer depth; SHALL be >= RD_LATENCY (elaboration-time check).
REQ-005 Clock and reset: one clock, clk; reset is synchronous and active-high, named rst.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  request may be accepted this cycle.
REQ-010 req_we_n  in  1  0 = write, 1 = read.
REQ-011 req_addr  in  ADDR_WIDTH  word address.
REQ-012 req_wdata  in  DATA_WIDTH  write data.
REQ-013 req_be  in  DATA_WIDTH/8  byte enables for writes; ignored on reads.
REQ-014 rsp_valid  out  1  read data available.
REQ-015 rsp_ready  in  1  consumer accepts read data.
REQ-016 rsp_rdata  out  DATA_WIDTH  read data.

Function
REQ-017 Two-state FSM: INIT and RUN. INIT SHALL write zero to address 0..2**ADDR_WIDTH-1, one per cycle, then go to RUN.
REQ-018 req_ready SHALL be 0 in INIT and SHALL be 1 in RUN only when outstanding < RSP_DEPTH. It SHALL be driven combinationally from registered state only, with no path from req_valid.
REQ-019 A request is accepted on a clk edge where req_valid && req_ready; at most one per cycle, reads and writes mixed freely.
REQ-020 Write accept: the addressed word SHALL be updated on the accept edge, only in bytes whose req_be bit is 1. A write with all-zero req_be SHALL be accepted as a no-op.
REQ-021 Read accept: the array SHALL be sampled on the accept edge. With rsp_ready high and the buffer empty, rsp_valid SHALL rise exactly RD_LATENCY cycles after the accept cycle.
REQ-022 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-023 A read returns the data present at its accept edge; later writes to that address while the read is in flight SHALL NOT alter it.
REQ-024 Responses SHALL be returned strictly in acceptance order. rsp_rdata SHALL hold stable while rsp_valid && !rsp_ready.
REQ-025 outstanding counter (width clog2(RSP_DEPTH+1)): +1 on read accept, -1 on rsp_valid && rsp_ready, unchanged on both. It SHALL never exceed RSP_DEPTH and no response SHALL ever be dropped.
REQ-026 Full throughput: with rsp_ready held 1, back-to-back reads SHALL be accepted every cycle.

Reset
REQ-027 While rst = 1: state = INIT, init address = 0, outstanding = 0, read pipeline and response buffer emptied, req_ready = 0, rsp_valid = 0, rsp_rdata = 0.
REQ-028 rst asserted mid-operation SHALL discard all in-flight reads (rsp_valid = 0 the cycle after rst is sampled) and restart the INIT sweep. Memory content is lost.
REQ-029 After rst deasserts, req_ready SHALL stay 0 for exactly 2**ADDR_WIDTH cycles.

Structure
REQ-030 Shared package sram_pkg SHALL hold the default ADDR_WIDTH/DATA_WIDTH values, the FSM state enum (INIT, RUN) and the RD_LATENCY/RSP_DEPTH limits.
REQ-031 The response buffer SHALL be a separate sub-module sram_rsp_fifo (parametrised width/depth, registered output, count output). The storage array, read pipeline, FSM and counter stay in sram_pipe_ctrl.
REQ-032 No latches and no asynchronous logic; the storage array is inferable as synchronous RAM.

Verification (ADDR_WIDTH=4, DATA_WIDTH=16, RD_LATENCY=2, RSP_DEPTH=4)
REQ-033 Release rst -> req_ready 0 for 16 cycles then 1; read addr 5 -> rsp_rdata 0x0000, rsp_valid 2 cycles after accept.
REQ-034 Write addr 3 = 0xA5C3 be 2'b11, read addr 3 next cycle -> 0xA5C3. Then write 0xFFFF be 2'b01, read -> 0xA5FF.
REQ-035 rsp_ready held 0, 6 back-to-back reads -> exactly 4 accepted, req_ready 0. Raise rsp_ready -> 4 responses in order, then the remaining reads accepted.
REQ-036 Read addr 7 (holds 0x1111), then next cycle write addr 7 = 0x2222 -> the read returns 0x1111 and a subsequent read returns 0x2222.
REQ-037 rst pulsed with 3 reads outstanding -> rsp_valid 0 the next cycle, no stale response afterwards, INIT repeats, addr 3 reads 0x0000.
REQ-038 Continuous reads with rsp_ready = 1 for 20 cycles -> 20 accepts, 20 in-order responses, outstanding <= 2 throughout.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and parameter defaults for the pipelined SRAM controller.
// Holds the FSM state encoding and the legal read-latency range.
package sram_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int RD_LATENCY_DEF = 1;
    localparam int RSP_DEPTH_DEF  = 4;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_pipe_ctrl_if.sv
// Request/response bundle between a requester and the SRAM controller.
// master drives requests and accepts responses; slave is the controller.
interface sram_pipe_ctrl_if
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we_n;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we_n, req_addr, req_wdata, req_be,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we_n, req_addr, req_wdata, req_be,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Read-response buffer with the head entry held in an output register.
// The caller guarantees it never pushes into a full buffer.
module sram_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    rptr_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_left;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop    = pop && (cnt != '0);
    assign rptr_nxt  = do_pop ? ptr_inc(rptr) : rptr;
    assign cnt_left  = cnt - CW'(do_pop);
    assign out_valid = (cnt != '0);
    assign count     = cnt;

    // storage: plain write port, contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    // pointers, occupancy, and the head register that feeds out_data
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            if (push) begin
                wptr <= ptr_inc(wptr);
            end
            rptr <= rptr_nxt;
            cnt  <= cnt_left + CW'(push);
            if (cnt_left == '0) begin
                if (push) begin
                    out_data <= push_data;
                end
            end else begin
                out_data <= mem[rptr_nxt];
            end
        end
    end

endmodule

// File: rtl/sram_pipe_ctrl.sv
// Pipelined SRAM controller: zero-fill sweep after reset, byte-masked
// writes, fixed-latency reads returned in order through a response buffer.
module sram_pipe_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int RSP_DEPTH  = RSP_DEPTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    sram_pipe_ctrl_if.slave bus
);

    localparam int WORDS = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;
    localparam int CW    = $clog2(RSP_DEPTH + 1);

    if (DATA_WIDTH % 8 != 0) begin : g_dw_chk
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_lat_chk
        $error("RD_LATENCY out of range");
    end
    if (RSP_DEPTH < RD_LATENCY) begin : g_depth_chk
        $error("RSP_DEPTH must be >= RD_LATENCY");
    end

    state_e                state;
    state_e                state_nxt;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic                  accept;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  rsp_pop;
    logic                  push_v;
    logic [DATA_WIDTH-1:0] push_d;

    assign bus.req_ready = (state == RUN) && (outstanding < CW'(RSP_DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign rd_acc        = accept && bus.req_we_n;
    assign wr_acc        = accept && !bus.req_we_n;
    assign rsp_pop       = bus.rsp_valid && bus.rsp_ready;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // leave INIT once the last word has been cleared
    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT: if (init_addr == '1) state_nxt = RUN;
            RUN:  state_nxt = RUN;
        endcase
    end

    // sweep address for the zero-fill
    always_ff @(posedge clk) begin
        if (rst) begin
            init_addr <= '0;
        end else if (state == INIT) begin
            init_addr <= init_addr + ADDR_WIDTH'(1);
        end
    end

    // array write port: zero-fill during INIT, byte-masked writes in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[init_addr] <= '0;
            end else if (wr_acc) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.req_be[b]) begin
                        mem[bus.req_addr][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    if (RD_LATENCY == 1) begin : g_lat1
        assign push_v = rd_acc;
        assign push_d = mem[bus.req_addr];
    end else begin : g_latn
        logic [RD_LATENCY-2:0] stg_v;
        logic [DATA_WIDTH-1:0] stg_d [RD_LATENCY-1];

        // read-valid delay line, flushed by reset
        always_ff @(posedge clk) begin
            if (rst) begin
                stg_v <= '0;
            end else begin
                stg_v[0] <= rd_acc;
                for (int i = 1; i < RD_LATENCY - 1; i++) begin
                    stg_v[i] <= stg_v[i-1];
                end
            end
        end

        // stage 0 is the registered array read; later stages only delay it
        always_ff @(posedge clk) begin
            stg_d[0] <= mem[bus.req_addr];
            for (int i = 1; i < RD_LATENCY - 1; i++) begin
                stg_d[i] <= stg_d[i-1];
            end
        end

        assign push_v = stg_v[RD_LATENCY-2];
        assign push_d = stg_d[RD_LATENCY-2];
    end

    // reads accepted but not yet handed to the consumer
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (rd_acc && !rsp_pop) begin
            outstanding <= outstanding + CW'(1);
        end else if (!rd_acc && rsp_pop) begin
            outstanding <= outstanding - CW'(1);
        end
    end

    sram_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_v),
        .push_data (push_d),
        .pop       (bus.rsp_ready),
        .out_valid (bus.rsp_valid),
        .out_data  (bus.rsp_rdata),
        .count     (fifo_count)
    );

    // buffered responses are always a subset of the outstanding reads
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_count <= outstanding);
        end
    end

endmodule

// File: tb/tb_sram_pipe_ctrl.sv
// Directed bench for sram_pipe_ctrl with a 16-word x 16-bit array,
// read latency 2 and a 4-entry response buffer.
module tb_sram_pipe_ctrl;

    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int RDP = 4;
    localparam int NV  = 15;

    typedef struct {
        logic          we_n;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    be;
    } op_t;

    typedef struct {
        logic          we_n;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    be;
        logic [DW-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sram_pipe_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_pipe_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (LAT),
        .RSP_DEPTH  (RDP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_vec = 0;
    int            n_err = 0;
    op_t           ops[$];
    logic [DW-1:0] got[$];
    int            acc_cyc[$];
    int            rsp_cyc[$];
    int            cyc     = 0;
    int            n_acc   = 0;
    int            out_m   = 0;
    int            out_max = 0;
    vec_t          vt[NV];
    logic [DW-1:0] em[16];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_op(input logic we_n, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [1:0] be);
        op_t o;
        o.we_n  = we_n;
        o.addr  = a;
        o.wdata = d;
        o.be    = be;
        ops.push_back(o);
    endtask

    task automatic check_rsp(input string name, input logic [DW-1:0] exp);
        if (got.size() > 0) begin
            check(name, 32'(got.pop_front()), 32'(exp));
        end else begin
            check({name, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    // Called at posedge+1: drive the head op, observe handshakes at negedge.
    task automatic cycle_step();
        logic acc, rd, pop;
        if (ops.size() > 0) begin
            bus.req_valid = 1'b1;
            bus.req_we_n  = ops[0].we_n;
            bus.req_addr  = ops[0].addr;
            bus.req_wdata = ops[0].wdata;
            bus.req_be    = ops[0].be;
        end else begin
            bus.req_valid = 1'b0;
        end
        @(negedge clk);
        acc = bus.req_valid && bus.req_ready;
        rd  = acc && bus.req_we_n;
        pop = bus.rsp_valid && bus.rsp_ready;
        if (pop) begin
            got.push_back(bus.rsp_rdata);
            rsp_cyc.push_back(cyc);
        end
        if (rd) acc_cyc.push_back(cyc);
        if (acc) n_acc++;
        out_m = out_m + int'(rd) - int'(pop);
        if (out_m > out_max) out_max = out_m;
        @(posedge clk);
        #1;
        if (acc) void'(ops.pop_front());
        bus.req_valid = 1'b0;
        cyc++;
    endtask

    task automatic run_until(input int n_exp, input int budget, input string name);
        int b = 0;
        while ((ops.size() > 0 || got.size() < n_exp) && b < budget) begin
            cycle_step();
            b++;
        end
        check({name, "_done"}, 32'(ops.size() == 0 && got.size() >= n_exp), 32'd1);
    endtask

    task automatic clear_q();
        acc_cyc.delete();
        rsp_cyc.delete();
        got.delete();
    endtask

    // Called at posedge+1 right after reset release.
    task automatic wait_init(input string name);
        int n     = 0;
        int stale = 0;
        bit seen  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                seen = 1'b1;
                break;
            end
            n++;
            if (bus.rsp_valid) stale++;
            @(posedge clk);
            #1;
        end
        if (seen) begin
            @(posedge clk);
            #1;
        end
        check({name, "_ready_low_cycles"}, 32'(n), 32'd16);
        check({name, "_stale_rsp"}, 32'(stale), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want finish");
        $fatal(1);
    end

    initial begin
        int a0;
        bus.req_valid = 1'b0;
        bus.req_we_n  = 1'b1;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b1;

        vt[0]  = '{1'b1, 4'd5,  16'h0000, 2'b00, 16'h0000};
        vt[1]  = '{1'b0, 4'd3,  16'hA5C3, 2'b11, 16'h0000};
        vt[2]  = '{1'b1, 4'd3,  16'h0000, 2'b00, 16'hA5C3};
        vt[3]  = '{1'b0, 4'd3,  16'hFFFF, 2'b01, 16'h0000};
        vt[4]  = '{1'b1, 4'd3,  16'h0000, 2'b00, 16'hA5FF};
        vt[5]  = '{1'b0, 4'd7,  16'h1111, 2'b11, 16'h0000};
        vt[6]  = '{1'b0, 4'd9,  16'hBEEF, 2'b10, 16'h0000};
        vt[7]  = '{1'b1, 4'd9,  16'h0000, 2'b00, 16'hBE00};
        vt[8]  = '{1'b0, 4'd9,  16'h1234, 2'b00, 16'h0000};
        vt[9]  = '{1'b1, 4'd9,  16'h0000, 2'b00, 16'hBE00};
        vt[10] = '{1'b0, 4'd15, 16'hCAFE, 2'b11, 16'h0000};
        vt[11] = '{1'b1, 4'd15, 16'h0000, 2'b00, 16'hCAFE};
        vt[12] = '{1'b0, 4'd0,  16'h0102, 2'b01, 16'h0000};
        vt[13] = '{1'b1, 4'd0,  16'h0000, 2'b00, 16'h0002};
        vt[14] = '{1'b1, 4'd7,  16'h0000, 2'b00, 16'h1111};

        for (int i = 0; i < 16; i++) em[i] = 16'h0000;
        em[0]  = 16'h0002;
        em[3]  = 16'hA5FF;
        em[7]  = 16'h2222;
        em[9]  = 16'hBE00;
        em[15] = 16'hCAFE;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_init("init1");

        // single transactions, each read checked for data and latency
        for (int i = 0; i < NV; i++) begin
            clear_q();
            add_op(vt[i].we_n, vt[i].addr, vt[i].wdata, vt[i].be);
            run_until(vt[i].we_n ? 1 : 0, 20, $sformatf("vec%0d", i));
            if (vt[i].we_n) begin
                if (acc_cyc.size() > 0 && rsp_cyc.size() > 0) begin
                    check($sformatf("vec%0d_latency", i),
                          32'(rsp_cyc[0] - acc_cyc[0]), 32'(LAT));
                end else begin
                    check($sformatf("vec%0d_latency_seen", i), 32'd0, 32'd1);
                end
                check_rsp($sformatf("vec%0d_rdata", i), vt[i].exp);
            end
        end

        // back-pressure: six reads against a stalled consumer
        clear_q();
        bus.rsp_ready = 1'b0;
        a0 = n_acc;
        add_op(1'b1, 4'd3,  '0, '0);
        add_op(1'b1, 4'd7,  '0, '0);
        add_op(1'b1, 4'd9,  '0, '0);
        add_op(1'b1, 4'd15, '0, '0);
        add_op(1'b1, 4'd0,  '0, '0);
        add_op(1'b1, 4'd5,  '0, '0);
        repeat (10) cycle_step();
        check("bp_accepted", 32'(n_acc - a0), 32'd4);
        check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_hold_rdata", 32'(bus.rsp_rdata), 32'hA5FF);
        check("bp_no_pop", 32'(got.size()), 32'd0);
        bus.rsp_ready = 1'b1;
        run_until(6, 40, "bp");
        check_rsp("bp_rsp0", 16'hA5FF);
        check_rsp("bp_rsp1", 16'h1111);
        check_rsp("bp_rsp2", 16'hBE00);
        check_rsp("bp_rsp3", 16'hCAFE);
        check_rsp("bp_rsp4", 16'h0002);
        check_rsp("bp_rsp5", 16'h0000);
        check("bp_total_acc", 32'(n_acc - a0), 32'd6);

        // read in flight, then overwrite the same word, then re-read
        clear_q();
        add_op(1'b1, 4'd7, '0, '0);
        add_op(1'b0, 4'd7, 16'h2222, 2'b11);
        add_op(1'b1, 4'd7, '0, '0);
        run_until(2, 20, "haz");
        check_rsp("haz_old", 16'h1111);
        check_rsp("haz_new", 16'h2222);

        // twenty back-to-back reads with an always-ready consumer
        clear_q();
        out_m   = 0;
        out_max = 0;
        for (int i = 0; i < 20; i++) add_op(1'b1, AW'(i % 16), '0, '0);
        run_until(20, 60, "stream");
        check("stream_rd_accepts", 32'(acc_cyc.size()), 32'd20);
        if (acc_cyc.size() == 20) begin
            check("stream_span", 32'(acc_cyc[19] - acc_cyc[0]), 32'd19);
        end
        check("stream_outstanding_le2", 32'(out_max <= 2), 32'd1);
        for (int i = 0; i < 20; i++) begin
            check_rsp($sformatf("stream_rsp%0d", i), em[i % 16]);
        end

        // reset with three reads parked in the buffer
        clear_q();
        bus.rsp_ready = 1'b0;
        a0 = n_acc;
        add_op(1'b1, 4'd3, '0, '0);
        add_op(1'b1, 4'd7, '0, '0);
        add_op(1'b1, 4'd9, '0, '0);
        repeat (6) cycle_step();
        check("rst2_parked", 32'(n_acc - a0), 32'd3);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        ops.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst2_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst2_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        out_m = 0;
        clear_q();
        wait_init("init2");
        add_op(1'b1, 4'd3, '0, '0);
        run_until(1, 20, "rst2_rd");
        check_rsp("rst2_addr3", 16'h0000);
        check("rst2_no_extra", 32'(got.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
